siw_memory_bram_param: RTL and testbench

Parametrised dual-port block-RAM wrapper, the generic successor of the fixed 1024×32 SideGen BRAM wrappers, instantiated by the generated datapath as its local memory. It provides a per-port programmable write-enable delay of 0..MAX_DLY cycles so writes can be aligned with deep datapath pipelines, and an optional output register. It adds three things the fixed wrappers lack:
- a hardware clear sequencer driven by `init`;
- same-address write-collision detection and arbitration;
- `busy` and `collision` status outputs.

---
 rtl/siw_memory_bram_param_pkg.sv | 20 ++
 rtl/tp_mem_2r2w_param.sv | 32 +++
 rtl/siw_memory_bram_param.sv | 197 +++++++++++++++++++
 tb/tb_siw_memory_bram_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/siw_memory_bram_param_pkg.sv
// Shared definitions for the siw_memory_bram_param slice.
//   clr_state_t  : states of the memory clear sequencer
//   PORT_A_WINS  : arbitration when both ports write the same address in one cycle
//   sat_conf()   : clamps a write-enable delay select to the deepest delay stage
package siw_memory_bram_param_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_HOLD  = 2'd2
  } clr_state_t;

  localparam bit PORT_A_WINS = 1'b1;

  function automatic int unsigned sat_conf(input int unsigned conf,
                                           input int unsigned max_dly);
    return (conf > max_dly) ? max_dly : conf;
  endfunction

endpackage

// File: rtl/tp_mem_2r2w_param.sv
// Single-clock true dual-port RAM, read-first, no reset.
// Ports:
//   clk                     : clock
//   we_a/addr_a/din_a/dout_a : port A write enable, address, write data, read data
//   we_b/addr_b/din_b/dout_b : port B write enable, address, write data, read data
// Both ports read every cycle; a read of an address written in the same cycle
// returns the previous word. Should both ports write one address, port A lands.
module tp_mem_2r2w_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= din_b;
    if (we_a) mem[addr_a] <= din_a;
  end

endmodule

// File: rtl/siw_memory_bram_param.sv
// Parametrised dual-port BRAM wrapper for the generated datapath.
// Ports:
//   siw_memory_bram_param_clk / _reset     : clock, asynchronous active-high reset
//   siw_memory_bram_param_init             : flush delay lines and start a memory clear
//   siw_memory_bram_param_mem_sel          : host select, alternative port-A write qualifier
//   _enable_x, _write_en_x                 : write qualifier and undelayed write request
//   _address_x, _input_data_x              : address and write data (never delayed)
//   _mem_conf_x                            : write-enable delay select (saturates at MAX_DLY)
//   _output_data_x                         : read data (latency 1 or 2 with OUT_REG)
//   siw_memory_bram_param_busy             : high while the clear sequence runs
//   siw_memory_bram_param_collision        : one-cycle pulse after a same-address double write
module siw_memory_bram_param
  import siw_memory_bram_param_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int MAX_DLY = 3,
  parameter int CONF_W  = 2,
  parameter int OUT_REG = 1
) (
  input  logic              siw_memory_bram_param_clk,
  input  logic              siw_memory_bram_param_reset,
  input  logic              siw_memory_bram_param_init,
  input  logic              siw_memory_bram_param_mem_sel,
  input  logic              siw_memory_bram_param_enable_a,
  input  logic              siw_memory_bram_param_enable_b,
  input  logic              siw_memory_bram_param_write_en_a,
  input  logic              siw_memory_bram_param_write_en_b,
  input  logic [ADDR_W-1:0] siw_memory_bram_param_address_a,
  input  logic [ADDR_W-1:0] siw_memory_bram_param_address_b,
  input  logic [DATA_W-1:0] siw_memory_bram_param_input_data_a,
  input  logic [DATA_W-1:0] siw_memory_bram_param_input_data_b,
  input  logic [CONF_W-1:0] siw_memory_bram_param_mem_conf_a,
  input  logic [CONF_W-1:0] siw_memory_bram_param_mem_conf_b,
  output logic [DATA_W-1:0] siw_memory_bram_param_output_data_a,
  output logic [DATA_W-1:0] siw_memory_bram_param_output_data_b,
  output logic              siw_memory_bram_param_busy,
  output logic              siw_memory_bram_param_collision
);

  localparam int SEL_W = $clog2(MAX_DLY + 1);

  logic              clk;
  logic              rst;
  logic              init;
  assign clk  = siw_memory_bram_param_clk;
  assign rst  = siw_memory_bram_param_reset;
  assign init = siw_memory_bram_param_init;

  // Per-port write-enable delay lines; index 0 = port A, 1 = port B.
  logic              req_in   [2];
  logic [CONF_W-1:0] conf_in  [2];
  logic              wr_sel   [2];

  assign req_in[0]  = siw_memory_bram_param_write_en_a;
  assign req_in[1]  = siw_memory_bram_param_write_en_b;
  assign conf_in[0] = siw_memory_bram_param_mem_conf_a;
  assign conf_in[1] = siw_memory_bram_param_mem_conf_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dly
      // dly_reg[k-1] holds the request delayed by k cycles; tap 0 is the live input,
      // so a conf change only moves the tap and in-flight requests keep shifting.
      logic [MAX_DLY-1:0] dly_reg;
      logic [MAX_DLY:0]   taps;
      logic [SEL_W-1:0]   sel;

      assign taps = {dly_reg, req_in[gi]};
      assign sel  = SEL_W'(sat_conf(32'(conf_in[gi]), MAX_DLY));
      assign wr_sel[gi] = taps[sel];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dly_reg <= '0;
        end else if (init) begin
          dly_reg <= '0;
        end else begin
          dly_reg <= taps[MAX_DLY-1:0];
        end
      end
    end
  endgenerate

  logic wa;
  logic wb;
  assign wa = wr_sel[0] & (siw_memory_bram_param_enable_a | siw_memory_bram_param_mem_sel);
  assign wb = wr_sel[1] & siw_memory_bram_param_enable_b;

  // Clear sequencer
  clr_state_t        state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              busy_reg;
  logic              collision_reg;
  logic              clearing;

  assign clearing = (state_reg == CLR_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLR_IDLE;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        CLR_IDLE: begin
          if (init) begin
            state_reg   <= CLR_CLEAR;
            clr_cnt_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        CLR_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + 1'b1;
          if (&clr_cnt_reg) begin
            busy_reg  <= 1'b0;
            // A still-high init parks in HOLD so it cannot retrigger a clear.
            state_reg <= init ? CLR_HOLD : CLR_IDLE;
          end
        end
        CLR_HOLD: begin
          if (!init) state_reg <= CLR_IDLE;
        end
        default: begin
          state_reg <= CLR_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Port A is owned by the sequencer while clearing, so its address follows the counter.
  logic              ram_we_a_req;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_din_a;
  logic              collide;
  logic              drop_b;
  logic              ram_we_a;
  logic              ram_we_b;
  logic [DATA_W-1:0] ram_q_a;
  logic [DATA_W-1:0] ram_q_b;

  assign ram_we_a_req = clearing ? 1'b1        : wa;
  assign ram_addr_a   = clearing ? clr_cnt_reg : siw_memory_bram_param_address_a;
  assign ram_din_a    = clearing ? '0          : siw_memory_bram_param_input_data_a;

  assign collide  = ram_we_a_req & wb & (ram_addr_a == siw_memory_bram_param_address_b);
  // The clear zero always beats port B, whatever the user arbitration.
  assign drop_b   = collide & (PORT_A_WINS | clearing);
  assign ram_we_a = ram_we_a_req & ~(collide & ~drop_b);
  assign ram_we_b = wb & ~drop_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) collision_reg <= 1'b0;
    else     collision_reg <= collide;
  end

  tp_mem_2r2w_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_a   (ram_we_a),
    .addr_a (ram_addr_a),
    .din_a  (ram_din_a),
    .dout_a (ram_q_a),
    .we_b   (ram_we_b),
    .addr_b (siw_memory_bram_param_address_b),
    .din_b  (siw_memory_bram_param_input_data_b),
    .dout_b (ram_q_b)
  );

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] out_a_reg;
      logic [DATA_W-1:0] out_b_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_a_reg <= '0;
          out_b_reg <= '0;
        end else begin
          out_a_reg <= ram_q_a;
          out_b_reg <= ram_q_b;
        end
      end
      assign siw_memory_bram_param_output_data_a = out_a_reg;
      assign siw_memory_bram_param_output_data_b = out_b_reg;
    end else begin : g_noreg
      assign siw_memory_bram_param_output_data_a = ram_q_a;
      assign siw_memory_bram_param_output_data_b = ram_q_b;
    end
  endgenerate

  assign siw_memory_bram_param_busy      = busy_reg;
  assign siw_memory_bram_param_collision = collision_reg;

endmodule

// File: tb/tb_siw_memory_bram_param.sv
// Directed bench for siw_memory_bram_param (1024 x 32, MAX_DLY=3, OUT_REG=1).
module tb_siw_memory_bram_param;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 10;
  localparam int MAX_DLY = 3;
  localparam int CONF_W  = 3;
  localparam int OUT_REG = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              init;
  logic              mem_sel;
  logic              enable_a;
  logic              enable_b;
  logic              write_en_a;
  logic              write_en_b;
  logic [ADDR_W-1:0] address_a;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] input_data_a;
  logic [DATA_W-1:0] input_data_b;
  logic [CONF_W-1:0] mem_conf_a;
  logic [CONF_W-1:0] mem_conf_b;
  logic [DATA_W-1:0] output_data_a;
  logic [DATA_W-1:0] output_data_b;
  logic              busy;
  logic              collision;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  siw_memory_bram_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .MAX_DLY (MAX_DLY),
    .CONF_W  (CONF_W),
    .OUT_REG (OUT_REG)
  ) dut (
    .siw_memory_bram_param_clk           (clk),
    .siw_memory_bram_param_reset         (rst),
    .siw_memory_bram_param_init          (init),
    .siw_memory_bram_param_mem_sel       (mem_sel),
    .siw_memory_bram_param_enable_a      (enable_a),
    .siw_memory_bram_param_enable_b      (enable_b),
    .siw_memory_bram_param_write_en_a    (write_en_a),
    .siw_memory_bram_param_write_en_b    (write_en_b),
    .siw_memory_bram_param_address_a     (address_a),
    .siw_memory_bram_param_address_b     (address_b),
    .siw_memory_bram_param_input_data_a  (input_data_a),
    .siw_memory_bram_param_input_data_b  (input_data_b),
    .siw_memory_bram_param_mem_conf_a    (mem_conf_a),
    .siw_memory_bram_param_mem_conf_b    (mem_conf_b),
    .siw_memory_bram_param_output_data_a (output_data_a),
    .siw_memory_bram_param_output_data_b (output_data_b),
    .siw_memory_bram_param_busy          (busy),
    .siw_memory_bram_param_collision     (collision)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_b(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem_conf_b   = '0;
    address_b    = a;
    input_data_b = d;
    enable_b     = 1'b1;
    write_en_b   = 1'b1;
    tick();
    write_en_b   = 1'b0;
    enable_b     = 1'b0;
    $display("write B addr=0x%03h data=0x%08h", a, d);
  endtask

  task automatic rd_b(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    address_b = a;
    tick();
    tick();
    d = output_data_b;
    $display("read  B addr=0x%03h data=0x%08h", a, d);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int n;
    int m;
    logic busy_seen;

    rst = 1'b1; init = 1'b0; mem_sel = 1'b0;
    enable_a = 1'b0; enable_b = 1'b0; write_en_a = 1'b0; write_en_b = 1'b0;
    address_a = '0; address_b = '0; input_data_a = '0; input_data_b = '0;
    mem_conf_a = '0; mem_conf_b = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_collision", {31'b0, collision}, 32'h0);
    chk("rst_out_a", output_data_a, 32'h0);
    chk("rst_out_b", output_data_b, 32'h0);
    rst = 1'b0;
    tick();

    // Seed non-zero words, then a one-cycle init pulse clears everything
    wr_b(10'h000, 32'h0BADF00D);
    wr_b(10'h3FF, 32'hFEEDFACE);
    wr_b(10'h123, 32'h12312312);
    wr_b(10'h200, 32'h12345678);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("clr_busy_rise", {31'b0, busy}, 32'h1);
    n = 0;
    while (busy && n < 2000) begin
      if (n == 700) begin
        // counter is at 0x2BC, already past 0x200
        address_b = 10'h200; input_data_b = 32'hCAFEF00D;
        enable_b = 1'b1; write_en_b = 1'b1;
      end
      tick();
      write_en_b = 1'b0; enable_b = 1'b0;
      n++;
    end
    $display("clear pulse busy cycles=%0d", n);
    chk("clr_busy_cycles", n, 32'd1024);
    rd_b(10'h000, d); chk("clr_0x000", d, 32'h0);
    rd_b(10'h3FF, d); chk("clr_0x3ff", d, 32'h0);
    rd_b(10'h123, d); chk("clr_0x123", d, 32'h0);
    rd_b(10'h200, d); chk("clr_midwrite_0x200", d, 32'hCAFEF00D);
    repeat (4) tick();

    // conf_a=2: request at E0, address/data at E2 are committed
    mem_conf_a = 3'd2; enable_a = 1'b1; write_en_a = 1'b1;
    address_a = 10'h003; input_data_a = 32'h03030303; tick();
    write_en_a = 1'b0;
    address_a = 10'h004; input_data_a = 32'h04040404; tick();
    address_a = 10'h005; input_data_a = 32'hDEADBEEF; tick();
    address_a = 10'h006; input_data_a = 32'h06060606; tick();
    enable_a = 1'b0; mem_conf_a = '0;
    address_a = 10'h004; tick(); tick();
    address_a = 10'h005;
    tick();
    chk("lat_a_one_edge", output_data_a, 32'h0);
    tick();
    chk("lat_a_two_edges", output_data_a, 32'hDEADBEEF);
    rd_b(10'h003, d); chk("dly2_0x003", d, 32'h0);
    rd_b(10'h004, d); chk("dly2_0x004", d, 32'h0);
    rd_b(10'h006, d); chk("dly2_0x006", d, 32'h0);
    repeat (4) tick();

    // conf_b=7 saturates to 3: only the E3 address/data land
    mem_conf_b = 3'd7; enable_b = 1'b1; write_en_b = 1'b1;
    address_b = 10'h020; input_data_b = 32'h20202020; tick();
    write_en_b = 1'b0;
    address_b = 10'h021; input_data_b = 32'h21212121; tick();
    address_b = 10'h022; input_data_b = 32'h22222222; tick();
    address_b = 10'h023; input_data_b = 32'h77777777; tick();
    address_b = 10'h024; input_data_b = 32'h24242424; tick();
    enable_b = 1'b0; mem_conf_b = '0;
    rd_b(10'h023, d); chk("sat_0x023", d, 32'h77777777);
    rd_b(10'h022, d); chk("sat_0x022", d, 32'h0);
    rd_b(10'h024, d); chk("sat_0x024", d, 32'h0);
    repeat (4) tick();

    // Simultaneous writes to different addresses: no collision
    enable_a = 1'b1; enable_b = 1'b1; write_en_a = 1'b1; write_en_b = 1'b1;
    address_a = 10'h010; input_data_a = 32'hAAAA0010;
    address_b = 10'h011; input_data_b = 32'hBBBB0011;
    tick();
    chk("nocoll_pulse", {31'b0, collision}, 32'h0);
    // Same address: A wins, collision pulses one cycle
    address_a = 10'h3FF; input_data_a = 32'h11111111;
    address_b = 10'h3FF; input_data_b = 32'h22222222;
    tick();
    write_en_a = 1'b0; write_en_b = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
    chk("coll_pulse", {31'b0, collision}, 32'h1);
    tick();
    chk("coll_drop", {31'b0, collision}, 32'h0);
    rd_b(10'h3FF, d); chk("coll_0x3ff", d, 32'h11111111);
    rd_b(10'h010, d); chk("nocoll_0x010", d, 32'hAAAA0010);
    rd_b(10'h011, d); chk("nocoll_0x011", d, 32'hBBBB0011);

    // mem_sel qualifies port A in place of enable_a
    enable_a = 1'b0; mem_sel = 1'b1; write_en_a = 1'b1;
    address_a = 10'h030; input_data_a = 32'hA5A5A5A5; tick();
    mem_sel = 1'b0;
    address_a = 10'h031; input_data_a = 32'h5A5A5A5A; tick();
    write_en_a = 1'b0;
    rd_b(10'h030, d); chk("memsel_write", d, 32'hA5A5A5A5);
    rd_b(10'h031, d); chk("memsel_nowrite", d, 32'h0);

    // init held for 2000 cycles: exactly one clear, B write into cleared address collides
    init = 1'b1;
    tick();
    n = 0;
    while (busy && n < 2000) begin
      if (n == 32'h50) begin
        address_b = 10'h050; input_data_b = 32'hBADBAD00;
        enable_b = 1'b1; write_en_b = 1'b1;
      end
      tick();
      write_en_b = 1'b0; enable_b = 1'b0;
      n++;
      if (n == 32'h51) chk("clr_coll_pulse", {31'b0, collision}, 32'h1);
      if (n == 32'h52) chk("clr_coll_drop", {31'b0, collision}, 32'h0);
    end
    $display("clear held busy cycles=%0d", n);
    chk("held_busy_cycles", n, 32'd1024);
    m = n;
    busy_seen = 1'b0;
    while (m < 2000) begin
      tick();
      if (busy) busy_seen = 1'b1;
      m++;
    end
    chk("held_no_restart", {31'b0, busy_seen}, 32'h0);
    init = 1'b0;
    repeat (3) tick();
    chk("held_release_idle", {31'b0, busy}, 32'h0);
    rd_b(10'h050, d); chk("clr_coll_zero_wins", d, 32'h0);
    rd_b(10'h3FF, d); chk("held_clr_0x3ff", d, 32'h0);
    rd_b(10'h030, d); chk("held_clr_0x030", d, 32'h0);

    // Reset in the middle of a clear
    wr_b(10'h0FF, 32'hFFFF0000);
    wr_b(10'h100, 32'h10010010);
    wr_b(10'h200, 32'h20020020);
    wr_b(10'h3FF, 32'h3FF3FF3F);
    init = 1'b1;
    tick();
    init = 1'b0;
    repeat (32'h100) tick();
    chk("midclr_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    chk("midclr_rst_busy", {31'b0, busy}, 32'h0);
    #1;
    rst = 1'b0;
    tick();
    chk("midclr_after_busy", {31'b0, busy}, 32'h0);
    rd_b(10'h0FF, d); chk("midclr_0x0ff", d, 32'h0);
    rd_b(10'h100, d); chk("midclr_0x100", d, 32'h10010010);
    rd_b(10'h200, d); chk("midclr_0x200", d, 32'h20020020);
    rd_b(10'h3FF, d); chk("midclr_0x3ff", d, 32'h3FF3FF3F);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
